// File: rtl/enigma_char_sequencer_if.sv
// Host character stream and enigma core handshake signals for the character sequencer.
// The sequencer takes the slave view; the host/core side (or a bench) takes the master view.
interface enigma_char_sequencer_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       core_set;
  logic       core_en;
  logic       core_dec;
  logic       core_valid;
  logic [7:0] core_din;
  logic [7:0] core_dout;
  logic       core_done;

  modport slave (
    input  in_valid, in_data, out_ready, core_dout, core_done,
    output in_ready, out_valid, out_data,
    output core_set, core_en, core_dec, core_valid, core_din
  );

  modport master (
    output in_valid, in_data, out_ready, core_dout, core_done,
    input  in_ready, out_valid, out_data,
    input  core_set, core_en, core_dec, core_valid, core_din
  );
endinterface

// File: rtl/enigma_char_sequencer.sv
// Feeds host characters one at a time through the enigma core (letters) or straight through
// (everything else), preserving order, with per-character timeout and in/out FIFOs.
module enigma_char_sequencer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cfg_start,
  input  logic                   dec_mode,
  enigma_char_sequencer_if.slave bus,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [15:0]            char_count
);
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ISSUE, S_WAIT, S_STORE} state_t;

  state_t          r_state, w_next;
  logic            r_pending, r_cfgd, r_dec, r_terr;
  logic [7:0]      r_din, r_result;
  logic [15:0]     r_ccount;
  logic [TW-1:0]   r_tcnt;

  logic [7:0]      r_imem [DEPTH];
  logic [AW-1:0]   r_iwptr, r_irptr;
  logic [CW-1:0]   r_icnt;
  logic [7:0]      r_omem [DEPTH];
  logic [AW-1:0]   r_owptr, r_orptr;
  logic [CW-1:0]   r_ocnt;

  logic            w_iwr, w_ipop, w_owr, w_opop, w_ofull, w_inempty, w_is_letter, w_tmo;
  logic [7:0]      w_ihead;

  assign w_ihead     = r_imem[r_irptr];
  assign w_inempty   = (r_icnt != '0);
  assign w_ofull     = (r_ocnt == FULL);
  assign w_iwr       = bus.in_valid && (r_icnt != FULL);
  assign w_opop      = bus.out_ready && (r_ocnt != '0);
  assign w_is_letter = (w_ihead >= 8'h41) && (w_ihead <= 8'h5A);
  assign w_tmo       = (r_state == S_WAIT) && !bus.core_done && (r_tcnt == TMO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_ipop         = 1'b0;
    w_owr          = 1'b0;
    bus.core_set   = 1'b0;
    bus.core_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pending) begin
          w_next = S_SETUP;
        end else if (r_cfgd && w_inempty) begin
          w_ipop = 1'b1;
          w_next = w_is_letter ? S_ISSUE : S_STORE;
        end
      end
      S_SETUP: begin
        bus.core_set = 1'b1;
        w_next       = S_IDLE;
      end
      S_ISSUE: begin
        bus.core_valid = 1'b1;
        w_next         = S_WAIT;
      end
      S_WAIT: begin
        if (bus.core_done || w_tmo) w_next = S_STORE;
      end
      S_STORE: begin
        if (!w_ofull) begin
          w_owr  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // cfg_start arriving during SETUP re-arms the pending flag rather than being lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
      r_cfgd    <= 1'b0;
      r_dec     <= 1'b0;
      r_terr    <= 1'b0;
      r_ccount  <= '0;
      r_din     <= '0;
    end else begin
      r_pending <= cfg_start || (r_pending && (r_state != S_SETUP));
      if (r_state == S_SETUP) begin
        r_cfgd   <= 1'b1;
        r_dec    <= dec_mode;
        r_terr   <= 1'b0;
        r_ccount <= '0;
      end
      if (w_tmo) r_terr <= 1'b1;
      if (w_ipop && w_is_letter) r_din <= w_ihead;
      if (w_owr && (r_ccount != 16'hFFFF)) r_ccount <= r_ccount + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ipop && !w_is_letter)                  r_result <= w_ihead;
    else if ((r_state == S_WAIT) && bus.core_done) r_result <= bus.core_dout;
    else if (w_tmo)                              r_result <= 8'h3F;
    if (r_state == S_ISSUE)     r_tcnt <= '0;
    else if (r_state == S_WAIT) r_tcnt <= r_tcnt + TW'(1);
    if (w_iwr) r_imem[r_iwptr] <= bus.in_data;
    if (w_owr) r_omem[r_owptr] <= r_result;
  end

  // Separate occupancy counters tell full from empty when the pointers coincide
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_iwptr <= '0;
      r_irptr <= '0;
      r_icnt  <= '0;
      r_owptr <= '0;
      r_orptr <= '0;
      r_ocnt  <= '0;
    end else begin
      if (w_iwr)  r_iwptr <= r_iwptr + AW'(1);
      if (w_ipop) r_irptr <= r_irptr + AW'(1);
      if (w_iwr && !w_ipop)      r_icnt <= r_icnt + CW'(1);
      else if (!w_iwr && w_ipop) r_icnt <= r_icnt - CW'(1);
      if (w_owr)  r_owptr <= r_owptr + AW'(1);
      if (w_opop) r_orptr <= r_orptr + AW'(1);
      if (w_owr && !w_opop)      r_ocnt <= r_ocnt + CW'(1);
      else if (!w_owr && w_opop) r_ocnt <= r_ocnt - CW'(1);
    end
  end

  assign bus.in_ready  = (r_icnt != FULL);
  assign bus.out_valid = (r_ocnt != '0);
  assign bus.out_data  = (r_ocnt != '0) ? r_omem[r_orptr] : 8'h00;
  assign bus.core_en   = r_cfgd;
  assign bus.core_dec  = r_dec;
  assign bus.core_din  = r_din;
  assign busy          = (r_state != S_IDLE) || (r_icnt != '0) || (r_ocnt != '0);
  assign timeout_err   = r_terr;
  assign char_count    = r_ccount;
endmodule

// File: tb/tb_enigma_char_sequencer.sv
// Directed and randomized checks of enigma_char_sequencer against a character-level model
// (rotating-letter core, bypass for non-letters, '?' on timeout).
module tb_enigma_char_sequencer;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 10;
  localparam int KEY     = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        dec_mode = 1'b0;
  logic        busy, timeout_err;
  logic [15:0] char_count;

  enigma_char_sequencer_if bus();

  enigma_char_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .dec_mode(dec_mode),
    .bus(bus), .busy(busy), .timeout_err(timeout_err), .char_count(char_count)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  function automatic logic [7:0] core_fn(input logic [7:0] c);
    return 8'((int'(c) - 65 + KEY) % 26 + 65);
  endfunction

  function automatic bit is_letter(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  // Core model and monitors; core_lat: >0 fixed latency, 0 never answers, <0 random 1..6
  int         core_lat = 5;
  int         cd = 0;
  int         force_req = 0, force_ack = 0;
  int         set_cnt = 0, valid_cnt = 0, last_valid_cyc = 0;
  logic [7:0] last_din = 8'h00;
  logic       ov_prev = 1'b0;
  int         rise_q[$];
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (bus.core_set) set_cnt <= set_cnt + 1;
    if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_data);
    if (bus.out_valid && !ov_prev) rise_q.push_back(cyc_n);
    ov_prev <= bus.out_valid;
    if (!reset_n) begin
      cd            <= 0;
      bus.core_done <= 1'b0;
      bus.core_dout <= 8'h00;
    end else begin
      bus.core_done <= 1'b0;
      if (force_req != force_ack) begin
        force_ack     <= force_req;
        bus.core_done <= 1'b1;
        bus.core_dout <= 8'h55;
      end
      if (bus.core_valid) begin
        valid_cnt      <= valid_cnt + 1;
        last_din       <= bus.core_din;
        last_valid_cyc <= cyc_n;
        cd             <= (core_lat < 0) ? int'($urandom_range(1, 6)) : core_lat;
      end else if (cd > 1) begin
        cd <= cd - 1;
      end else if (cd == 1) begin
        cd            <= 0;
        bus.core_done <= 1'b1;
        bus.core_dout <= core_fn(last_din);
      end
    end
  end

  int         n_tests = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int         got_rd = 0, rise_rd = 0;
  int         exp_count = 0;
  bit         tmo_mode = 1'b0;
  bit         rand_ready = 1'b0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    cyc();
  endtask

  task automatic push(input logic [7:0] c, output int acc);
    bus.in_valid = 1'b1;
    bus.in_data  = c;
    for (int b = 0; b < 400 && !bus.in_ready; b++) tick();
    acc = cyc_n;
    if (!bus.in_ready) chk("push_ready", 32'(bus.in_ready), 32'd1);
    else begin
      exp_q.push_back(!is_letter(c) ? c : (tmo_mode ? 8'h3F : core_fn(c)));
      exp_count++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int b = 0; b < 800 && busy; b++) tick();
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic configure(input logic dm);
    dec_mode  = dm;
    cfg_start = 1'b1;
    cyc();
    cfg_start = 1'b0;
    repeat (4) cyc();
    exp_count = 0;
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_len"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && (got_rd + i) < got_q.size(); i++)
      chk({tag, "_data"}, 32'(got_q[got_rd + i]), 32'(exp_q[i]));
    got_rd  = got_q.size();
    rise_rd = rise_q.size();
    exp_q.delete();
    chk({tag, "_count"}, 32'(char_count), 32'(exp_count));
  endtask

  initial begin
    int n0, n1, v0, s0, acc;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h41;
    bus.out_ready = 1'b1;
    cfg_start     = 1'b1;
    dec_mode      = 1'b1;

    // Reset with stimulus active
    repeat (3) cyc();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_core_set", 32'(bus.core_set), 32'd0);
    chk("rst_core_valid", 32'(bus.core_valid), 32'd0);
    chk("rst_core_en", 32'(bus.core_en), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_char_count", 32'(char_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    bus.in_valid = 1'b0;
    cfg_start    = 1'b0;
    reset_n      = 1'b1;
    repeat (4) cyc();
    chk("post_rst_core_en", 32'(bus.core_en), 32'd0);

    // Configure in decrypt mode and send one letter through the core
    s0 = set_cnt;
    configure(1'b1);
    chk("cfg_set_pulses", 32'(set_cnt - s0), 32'd1);
    chk("cfg_core_dec", 32'(bus.core_dec), 32'd1);
    chk("cfg_core_en", 32'(bus.core_en), 32'd1);
    v0 = valid_cnt;
    push(8'h41, n0);
    wait_idle("idle_letter");
    chk("letter_valids", 32'(valid_cnt - v0), 32'd1);
    chk("letter_din", 32'(last_din), 32'h41);
    chk("letter_issue_lat", 32'(last_valid_cyc - n0), 32'd2);
    chk("letter_out_lat", 32'(rise_q[rise_rd] - last_valid_cyc), 32'd7);
    compare_out("letter");

    // Mixed bypass / letter / bypass, order preserved
    configure(1'b1);
    chk("cfg2_count_clear", 32'(char_count), 32'd0);
    v0 = valid_cnt;
    push(8'h20, n0);
    push(8'h5A, n1);
    push(8'h2E, n1);
    wait_idle("idle_mixed");
    chk("mixed_valids", 32'(valid_cnt - v0), 32'd1);
    chk("mixed_din", 32'(last_din), 32'h5A);
    chk("bypass_lat", 32'(rise_q[rise_rd] - n0), 32'd3);
    compare_out("mixed");

    // done on the last WAIT cycle beats the timeout
    core_lat = TIMEOUT - 1;
    push(8'h46, n0);
    wait_idle("idle_late_done");
    chk("late_done_no_err", 32'(timeout_err), 32'd0);
    compare_out("late_done");

    // Hung core: '?' after TIMEOUT cycles, then a normal character
    core_lat = 0;
    tmo_mode = 1'b1;
    push(8'h43, n0);
    wait_idle("idle_tmo");
    chk("tmo_out_lat", 32'(rise_q[rise_rd] - last_valid_cyc), 32'(TIMEOUT + 1));
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    compare_out("tmo");
    core_lat = 5;
    tmo_mode = 1'b0;
    v0 = valid_cnt;
    push(8'h44, n0);
    wait_idle("idle_after_tmo");
    chk("after_tmo_valids", 32'(valid_cnt - v0), 32'd1);
    chk("after_tmo_err_sticky", 32'(timeout_err), 32'd1);
    compare_out("after_tmo");
    configure(1'b0);
    chk("cfg3_err_clear", 32'(timeout_err), 32'd0);
    chk("cfg3_core_dec", 32'(bus.core_dec), 32'd0);
    chk("cfg3_core_en", 32'(bus.core_en), 32'd1);

    // Backpressure: fill output FIFO, STORE slot and input FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2 * DEPTH + 1; i++) push(8'(8'h30 + $urandom_range(0, 9)), n0);
    repeat (6) cyc();
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_count", 32'(char_count), 32'(DEPTH));
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h21;
    repeat (3) cyc();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("idle_bp");
    compare_out("bp");

    // Randomized characters, core latency and output backpressure
    core_lat   = -1;
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c;
      c = ($urandom_range(0, 1) == 1) ? 8'(65 + $urandom_range(0, 25)) : 8'($urandom_range(0, 255));
      push(c, n0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready    = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle("idle_rand");
    compare_out("rand");

    // Reset while waiting on the core; a late done must be ignored
    core_lat = 0;
    v0 = valid_cnt;
    push(8'h4B, n0);
    push(8'h30, n0);
    push(8'h4C, n0);
    repeat (3) cyc();
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_valids", 32'(valid_cnt - v0), 32'd1);
    reset_n = 1'b0;
    repeat (2) cyc();
    chk("mid_rst_core_en", 32'(bus.core_en), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    reset_n = 1'b1;
    exp_q.delete();
    exp_count = 0;
    force_req++;
    repeat (10) cyc();
    chk("late_done_out_valid", 32'(bus.out_valid), 32'd0);
    chk("late_done_busy", 32'(busy), 32'd0);
    chk("late_done_core_en", 32'(bus.core_en), 32'd0);
    chk("late_done_entries", 32'(got_q.size() - got_rd), 32'd0);
    configure(1'b0);
    repeat (8) cyc();
    chk("recfg_core_en", 32'(bus.core_en), 32'd1);
    chk("recfg_no_issue", 32'(valid_cnt - v0), 32'd1);
    chk("recfg_out_valid", 32'(bus.out_valid), 32'd0);
    compare_out("recfg");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests so far %0d", n_tests);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/enigma_char_sequencer.md
Name: enigma_char_sequencer

Overview:
- Host-side initiator for the enigma core's valid/done character handshake.
- Buffers incoming host characters and configures the core with a one-cycle set pulse.
- Issues one character at a time on core_valid/core_din, waits for core_done, then returns the result to the host through an output FIFO.
- Non-letter characters bypass the core. Order is preserved. A per-character timeout guards against a hung core.

Parameters:
- DEPTH, 16, entries in each of the input and output FIFOs; power of two, minimum 2.
- TIMEOUT, 64, cycles waited in WAIT for core_done before error; minimum 2.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- cfg_start  in  1  pulse: request core (re)configuration
- dec_mode  in  1  mode; sampled on entry to SETUP
- in_valid  in  1  host character valid
- in_data  in  8  host character
- in_ready  out  1  input FIFO not full
- out_valid  out  1  output FIFO not empty
- out_data  out  8  output FIFO head
- out_ready  in  1  host accepts out_data
- core_set  out  1  one-cycle configuration pulse to core
- core_en  out  1  core enable; high while configured
- core_dec  out  1  registered dec_mode
- core_valid  out  1  one-cycle character strobe
- core_din  out  8  character to core, registered
- core_dout  in  8  core result
- core_done  in  1  core result strobe
- busy  out  1  FSM not in IDLE, or either FIFO non-empty
- timeout_err  out  1  sticky; cleared in SETUP
- char_count  out  16  characters written to output FIFO; saturates at 0xFFFF; cleared in SETUP

Behaviour:
- Reset values: all outputs 0, except in_ready=1. Reset also clears both FIFOs, the FSM (to IDLE), the configured flag and the pending-cfg flag.
- Reset mid-operation abandons any in-flight character. A core_done arriving after reset is ignored, because it is only sampled in WAIT.
- Input FIFO:
  - Write when in_valid & in_ready.
  - in_ready = registered count != DEPTH. A simultaneous pop while full does not admit a write that cycle.
- Output FIFO:
  - Pop when out_valid & out_ready.
  - Write only from STORE, and only when not full.
  - out_data is the head entry; it is stable while out_valid and not popped.
- cfg_start:
  - Sets the pending flag in any state.
  - The pending flag is serviced only from IDLE; it takes priority over issuing a character.
- FSM states:
  - IDLE:
    - If pending, go to SETUP.
    - Else, if configured and input FIFO non-empty, pop the head:
      - 0x41..0x5A ('A'..'Z'): latch it into core_din, go to ISSUE.
      - Any other value: latch it as the result, go to STORE (bypass, no core traffic).
    - If not configured, characters remain queued.
  - SETUP (1 cycle):
    - core_set=1, core_dec<=dec_mode.
    - Clear timeout_err, char_count and the pending flag; set configured.
    - Go to IDLE.
  - ISSUE (1 cycle): core_valid=1 with core_din, clear the timeout counter, go to WAIT.
  - WAIT:
    - core_done=1: latch core_dout as the result, go to STORE.
    - Otherwise increment the counter. On reaching TIMEOUT-1 without done: result=0x3F ('?'), timeout_err<=1, go to STORE.
    - core_done in the same cycle as the final count: done wins.
  - STORE:
    - If the output FIFO is not full: write the result, increment char_count (saturating), go to IDLE.
    - Else hold in STORE; no new character is issued.
- core_en=configured. It stays high across re-configuration; SETUP only pulses core_set.
- Latency, measured from in_data write at cycle N into an empty FIFO in configured IDLE:
  - Letter: pop at N+1, core_valid at N+2; result appears in the output FIFO 2 cycles after core_done (STORE write, out_valid next cycle).
  - Bypass: out_valid at N+3.
- Exactly one character is in flight; core_valid never reasserts before done or timeout.
- FIFO pointers wrap modulo DEPTH. A separate count register distinguishes full from empty.

Test Plan:
- Reset: reset_n low with stimulus active -> in_ready=1; out_valid, core_set, core_valid, core_en, timeout_err, char_count all 0.
- cfg_start with dec_mode=1, then push 0x41; core model returns done with 0x42 five cycles after core_valid -> one core_set pulse, core_dec=1, one core_valid with core_din=0x41, out_data=0x42, char_count=1.
- Push 0x20, 0x5A, 0x2E -> core_valid only for 0x5A; output order 0x20, core result, 0x2E; char_count=3.
- Core model never asserts done -> exactly TIMEOUT cycles after core_valid, a 0x3F entry is written; timeout_err=1; the next character issues normally; a new cfg_start clears timeout_err.
- out_ready=0, push 2*DEPTH+1 bypass characters -> in_ready drops after output FIFO full + FSM holding in STORE + input FIFO full. Then out_ready=1 -> all accepted characters drain in order with no loss or duplication.
- Reset asserted during WAIT, then core_done pulses -> no output entry, state IDLE. core_en stays 0 and queued input is gone until a new cfg_start.
